rob_retire_buffer: RTL and testbench
====================================

Name: rob_retire_buffer

Overview:
- 32-entry in-order reorder buffer, directly upstream of the architectural-state map.
- Allocates up to 4 renamed instructions per cycle and records out-of-order completions.
- Retires up to 4 completed head entries per cycle, in program order, onto per-slot retire ports wired 1:1 to the arch-state retire inputs.
- Also returns each retired entry's old physical register to the free list.

Parameters:
- DEPTH, 32, ROB entries (power of two, ≥8).
- ARCH_W, 5, architectural register index width.
- PREG_W, 7, physical register index width.
- ID_W, 5, ROB index width (log2 DEPTH).

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rest  in  1  reset, synchronous, active-high.
- Stop  in  1  pipeline stall: blocks allocation and retirement.
- Flash  in  1  pipeline flush: empties the buffer.
- AllocValid  in  4  per-slot allocate request; must be contiguous from bit 0.
- AllocDestAble  in  4  per slot, entry writes a destination register.
- AllocArch  in  4*ARCH_W  destination arch register; slot k at bits [k*ARCH_W +: ARCH_W].
- AllocPhy  in  4*PREG_W  newly mapped physical register.
- AllocOldPhy  in  4*PREG_W  previous mapping of the destination.
- AllocReady  out  1  at least 4 free entries.
- AllocRobId  out  4*ID_W  ROB index assigned to each slot; valid in the same cycle.
- CmplAble  in  4  completion write-back strobes.
- CmplRobId  in  4*ID_W  index of the completing entry.
- CmplExcp  in  4  exception flag for the completing entry (macro-gated).
- RetireAble  out  4  slot k retires with a destination write.
- RetireAR  out  4*ARCH_W  retired arch register, per slot.
- RetirePR  out  4*PREG_W  retired physical register, per slot.
- FreeAble  out  4  slot k frees its old physical register.
- FreePR  out  4*PREG_W  old physical register to free.
- RetireCnt  out  3  number of entries retired this cycle (0..4).
- ExcpValid  out  1  excepting entry reached head (macro-gated).
- ExcpRobId  out  ID_W  index of the excepting entry (macro-gated).

Behaviour:
- State per entry: Valid, Done, DestAble, Arch, Phy, OldPhy, Excp.
- Pointers: Head and Tail are ID_W+1 bits wide, with a wrap bit. Count = Tail - Head, range 0..DEPTH.
- Reset (Rest=1): all Valid/Done cleared; Head=Tail=0. All retire/free outputs, RetireCnt and ExcpValid are 0 in the following cycle.
- Priority: Rest > Flash > Stop > normal.
- Flash: same clearing as reset. All alloc, completion and retire activity in that cycle is discarded.
- AllocReady = (DEPTH - Count) ≥ 4. This is combinational from registered state only.
- AllocRobId slot k = (Tail + k) mod DEPTH. It is presented regardless of AllocValid.
- Allocation takes effect when AllocReady & !Stop & !Flash:
  - Writes n = popcount(AllocValid) entries.
  - Sets Valid=1, Done=0, Excp=0.
  - Tail += n.
- Non-contiguous AllocValid is a protocol error; behaviour is undefined.
- Completion: for each CmplAble[k], set Done (and Excp) of entry CmplRobId[k].
  - Applied even while Stop=1.
  - Ignored if the target entry is not Valid.
  - Duplicate IDs in one cycle are OR-merged.
- Retire selection (combinational):
  - Slot k is eligible iff entries Head..Head+k are all Valid & Done & !Excp, and k < Count.
  - The retired set is the eligible prefix of length m (0..4).
  - None retire if Stop or Flash is asserted.
- Retire outputs are registered: they appear the cycle after selection, and Head += m at the same edge.
  - Slot k with k < m: RetireAble[k] = DestAble, RetireAR/RetirePR = Arch/Phy, FreeAble[k] = DestAble, FreePR = OldPhy.
  - Slots k ≥ m: RetireAble[k] and FreeAble[k] are 0; address outputs are don't-care.
  - RetireCnt = m, including retired entries with no destination.
- Retired entries are cleared (Valid=0).
- Same-cycle allocate and retire: Count_next = Count + n - m.
  - AllocReady uses pre-retire Count.
  - A full buffer (Count=DEPTH) gives AllocReady=0 and still retires.
- Pointer wrap: indices are taken mod DEPTH. Full vs empty is distinguished by the wrap bit.
- Retire slots keep program order (slot 0 oldest). The consumer applies slots in ascending order, so the last write to the same arch register wins.

Optional Feature:
- Macro: ROB_RETIRE_EXCP_EN.
- Defined:
  - CmplExcp is recorded.
  - Retirement stops before a Done & Excp entry.
  - Once that entry is at Head, ExcpValid=1 and ExcpRobId=Head from the next cycle, held until Flash or Rest.
  - No retirement occurs while ExcpValid=1.
- Undefined:
  - CmplExcp, ExcpValid and ExcpRobId ports are absent.
  - The Excp bit is not stored.
  - Eligibility reduces to Valid & Done.

Test Plan:
- Reset, then allocate 4 (arch 1..4, phy 40..43, old 1..4) → AllocRobId = 0,1,2,3; AllocReady=1. Complete IDs 0..3 → next cycle RetireAble=4'b1111, RetirePR=40..43, FreePR=1..4, RetireCnt=4.
- Out-of-order completion: allocate 4, complete only IDs 1,2,3 → RetireCnt=0. Then complete ID 0 → all 4 retire in one cycle, slot order 0..3.
- Fill to 32 with no completions → AllocReady=0 at Count=29. A further alloc request is not accepted; Tail is unchanged.
- Wrap: retire 30, allocate 4 → AllocRobId = 30,31,0,1. Complete all → retire order 30,31,0,1 with correct PR.
- Stop=1 with 4 done entries → RetireCnt=0. Completions during Stop are still recorded. Release Stop → 4 retire next cycle. Flash with 10 entries → next cycle Count=0, AllocRobId slot0=0, no retire outputs.
- With ROB_RETIRE_EXCP_EN: complete ID 0 ok, ID 1 with Excp → ID 0 retires (RetireCnt=1), then ExcpValid=1, ExcpRobId=1, no further retire until Flash.

Source files
------------

// File: rtl/rob_retire_buffer.sv
// rob_retire_buffer: in-order reorder buffer, 4-wide allocate, out-of-order completion, 4-wide retire.
// Optional exception tracking is enabled by defining ROB_RETIRE_EXCP_EN.
module rob_retire_buffer #(
  parameter int DEPTH  = 32,
  parameter int ARCH_W = 5,
  parameter int PREG_W = 7,
  parameter int ID_W   = 5
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                Stop,
  input  logic                Flash,
  input  logic [3:0]          AllocValid,
  input  logic [3:0]          AllocDestAble,
  input  logic [4*ARCH_W-1:0] AllocArch,
  input  logic [4*PREG_W-1:0] AllocPhy,
  input  logic [4*PREG_W-1:0] AllocOldPhy,
  output logic                AllocReady,
  output logic [4*ID_W-1:0]   AllocRobId,
  input  logic [3:0]          CmplAble,
  input  logic [4*ID_W-1:0]   CmplRobId,
`ifdef ROB_RETIRE_EXCP_EN
  input  logic [3:0]          CmplExcp,
`endif
  output logic [3:0]          RetireAble,
  output logic [4*ARCH_W-1:0] RetireAR,
  output logic [4*PREG_W-1:0] RetirePR,
  output logic [3:0]          FreeAble,
  output logic [4*PREG_W-1:0] FreePR,
`ifdef ROB_RETIRE_EXCP_EN
  output logic [2:0]          RetireCnt,
  output logic                ExcpValid,
  output logic [ID_W-1:0]     ExcpRobId
`else
  output logic [2:0]          RetireCnt
`endif
);

  // Allocate handshake: slot k (AllocValid contiguous from bit 0) is accepted at the rising
  // edge iff AllocReady & !Stop & !Flash; AllocReady depends on registered state only.
  logic [DEPTH-1:0]  valid_q, done_q, dest_q;
  logic [ARCH_W-1:0] arch_q [DEPTH];
  logic [PREG_W-1:0] phy_q  [DEPTH];
  logic [PREG_W-1:0] old_q  [DEPTH];
  logic [ID_W:0]     head_q, tail_q, count;
  logic [ID_W-1:0]   hidx [4];
  logic [ID_W-1:0]   tidx [4];
  logic [ID_W-1:0]   cidx [4];
  logic [DEPTH-1:0]  excp_vec;
  logic              excp_hold;
  logic [2:0]        ret_m, alloc_n;
  logic              alloc_fire, chain;

  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign hidx[g] = head_q[ID_W-1:0] + ID_W'(g);
    assign tidx[g] = tail_q[ID_W-1:0] + ID_W'(g);
    assign cidx[g] = CmplRobId[g*ID_W +: ID_W];
    assign AllocRobId[g*ID_W +: ID_W] = tidx[g];
  end

  // The wrap bit makes count reach DEPTH when full instead of aliasing to 0.
  assign count      = tail_q - head_q;
  assign AllocReady = (count <= (ID_W+1)'(DEPTH - 4));
  assign alloc_fire = AllocReady & ~Stop & ~Flash;

  always_comb begin
    alloc_n = '0;
    for (int k = 0; k < 4; k++) alloc_n = alloc_n + {2'b00, AllocValid[k]};
  end

  // Retire the longest in-order prefix of completed, non-excepting head entries.
  always_comb begin
    ret_m = '0;
    chain = ~(Stop | Flash | excp_hold);
    for (int k = 0; k < 4; k++) begin
      chain = chain & valid_q[hidx[k]] & done_q[hidx[k]] & ~excp_vec[hidx[k]]
              & ((ID_W+1)'(k) < count);
      if (chain) ret_m = 3'(k + 1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest || Flash) begin
      valid_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      RetireAble <= '0;
      FreeAble   <= '0;
      RetireCnt  <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (CmplAble[k] && valid_q[cidx[k]]) done_q[cidx[k]] <= 1'b1;
      for (int k = 0; k < 4; k++) begin
        RetireAble[k] <= (3'(k) < ret_m) && dest_q[hidx[k]];
        FreeAble[k]   <= (3'(k) < ret_m) && dest_q[hidx[k]];
        if (3'(k) < ret_m) begin
          valid_q[hidx[k]] <= 1'b0;
          done_q[hidx[k]]  <= 1'b0;
        end
      end
      RetireCnt <= ret_m;
      head_q    <= head_q + (ID_W+1)'(ret_m);
      if (alloc_fire) begin
        for (int k = 0; k < 4; k++)
          if (AllocValid[k]) begin
            valid_q[tidx[k]] <= 1'b1;
            done_q[tidx[k]]  <= 1'b0;
            dest_q[tidx[k]]  <= AllocDestAble[k];
          end
        tail_q <= tail_q + (ID_W+1)'(alloc_n);
      end
    end
  end

  // Payload storage and retire address outputs carry no reset; they are qualified by valid bits.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      RetireAR[k*ARCH_W +: ARCH_W] <= arch_q[hidx[k]];
      RetirePR[k*PREG_W +: PREG_W] <= phy_q[hidx[k]];
      FreePR[k*PREG_W +: PREG_W]   <= old_q[hidx[k]];
    end
    if (!Rest && alloc_fire) begin
      for (int k = 0; k < 4; k++)
        if (AllocValid[k]) begin
          arch_q[tidx[k]] <= AllocArch[k*ARCH_W +: ARCH_W];
          phy_q[tidx[k]]  <= AllocPhy[k*PREG_W +: PREG_W];
          old_q[tidx[k]]  <= AllocOldPhy[k*PREG_W +: PREG_W];
        end
    end
  end

`ifdef ROB_RETIRE_EXCP_EN
  logic [DEPTH-1:0] excp_q;
  logic             excp_valid_q;
  logic [ID_W-1:0]  excp_id_q;

  assign excp_vec  = excp_q;
  assign excp_hold = excp_valid_q;
  assign ExcpValid = excp_valid_q;
  assign ExcpRobId = excp_id_q;

  // Once an excepting entry reaches head, the indication latches until flush or reset.
  always_ff @(posedge Clk) begin
    if (Rest || Flash) begin
      excp_q       <= '0;
      excp_valid_q <= 1'b0;
      excp_id_q    <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (CmplAble[k] && CmplExcp[k] && valid_q[cidx[k]]) excp_q[cidx[k]] <= 1'b1;
      if (alloc_fire)
        for (int k = 0; k < 4; k++)
          if (AllocValid[k]) excp_q[tidx[k]] <= 1'b0;
      if (!excp_valid_q && valid_q[hidx[0]] && done_q[hidx[0]] && excp_q[hidx[0]]) begin
        excp_valid_q <= 1'b1;
        excp_id_q    <= hidx[0];
      end
    end
  end
`else
  assign excp_vec  = '0;
  assign excp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Bench for rob_retire_buffer: directed vector table, hand sequences for fill/wrap/exception,
// then random traffic checked against a queue-based program-order model.
module tb_rob_retire_buffer;
  localparam int DEPTH = 32, ARCH_W = 5, PREG_W = 7, ID_W = 5;

  logic                Clk = 1'b0;
  logic                Rest, Stop, Flash;
  logic [3:0]          AllocValid, AllocDestAble, CmplAble;
  logic [4*ARCH_W-1:0] AllocArch;
  logic [4*PREG_W-1:0] AllocPhy, AllocOldPhy;
  logic                AllocReady;
  logic [4*ID_W-1:0]   AllocRobId, CmplRobId;
  logic [3:0]          RetireAble, FreeAble;
  logic [4*ARCH_W-1:0] RetireAR;
  logic [4*PREG_W-1:0] RetirePR, FreePR;
  logic [2:0]          RetireCnt;
`ifdef ROB_RETIRE_EXCP_EN
  logic [3:0]          CmplExcp;
  logic                ExcpValid;
  logic [ID_W-1:0]     ExcpRobId;
`endif

  rob_retire_buffer #(.DEPTH(DEPTH), .ARCH_W(ARCH_W), .PREG_W(PREG_W), .ID_W(ID_W)) dut (
    .Clk(Clk), .Rest(Rest), .Stop(Stop), .Flash(Flash),
    .AllocValid(AllocValid), .AllocDestAble(AllocDestAble), .AllocArch(AllocArch),
    .AllocPhy(AllocPhy), .AllocOldPhy(AllocOldPhy), .AllocReady(AllocReady),
    .AllocRobId(AllocRobId), .CmplAble(CmplAble), .CmplRobId(CmplRobId),
`ifdef ROB_RETIRE_EXCP_EN
    .CmplExcp(CmplExcp), .ExcpValid(ExcpValid), .ExcpRobId(ExcpRobId),
`endif
    .RetireAble(RetireAble), .RetireAR(RetireAR), .RetirePR(RetirePR),
    .FreeAble(FreeAble), .FreePR(FreePR), .RetireCnt(RetireCnt)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_miss = 0;
  bit pre_ok = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: valid entries in program order, oldest first.
  typedef struct {
    int id; bit dest; int arch; int phy; int old; bit done; bit excp;
  } ent_t;
  ent_t mq[$];
  int   m_tail = 0;
  bit   m_excpv = 0;
  int   m_excpid = 0;
  logic [3:0] e_rable = '0, e_fable = '0;
  int   e_cnt = 0;
  int   e_ar[4], e_pr[4], e_fpr[4];

  task automatic model_update();
    int m, n, cid;
    bit ready, set_ex;
    int ex_id;
    ent_t e;
    if (Rest || Flash) begin
      mq.delete();
      m_tail = 0; m_excpv = 0; e_rable = '0; e_fable = '0; e_cnt = 0;
      return;
    end
    ready  = (DEPTH - mq.size()) >= 4;
    set_ex = 0; ex_id = 0;
    if (!m_excpv && mq.size() > 0 && mq[0].done && mq[0].excp) begin
      set_ex = 1; ex_id = mq[0].id;
    end
    m = 0;
    if (!Stop && !m_excpv)
      while (m < 4 && m < mq.size() && mq[m].done && !mq[m].excp) m++;
    e_rable = '0; e_fable = '0; e_cnt = m;
    for (int k = 0; k < m; k++) begin
      e_rable[k] = mq[k].dest; e_fable[k] = mq[k].dest;
      e_ar[k] = mq[k].arch; e_pr[k] = mq[k].phy; e_fpr[k] = mq[k].old;
    end
    for (int k = 0; k < 4; k++)
      if (CmplAble[k]) begin
        cid = int'(CmplRobId[k*ID_W +: ID_W]);
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].id == cid) begin
            e = mq[i];
            e.done = 1;
`ifdef ROB_RETIRE_EXCP_EN
            if (CmplExcp[k]) e.excp = 1;
`endif
            mq[i] = e;
          end
      end
    for (int k = 0; k < m; k++) void'(mq.pop_front());
    if (ready && !Stop) begin
      n = 0;
      for (int k = 0; k < 4; k++)
        if (AllocValid[k]) begin
          e.id = (m_tail + k) % DEPTH; e.dest = AllocDestAble[k];
          e.arch = int'(AllocArch[k*ARCH_W +: ARCH_W]);
          e.phy  = int'(AllocPhy[k*PREG_W +: PREG_W]);
          e.old  = int'(AllocOldPhy[k*PREG_W +: PREG_W]);
          e.done = 0; e.excp = 0;
          mq.push_back(e);
          n++;
        end
      m_tail = (m_tail + n) % DEPTH;
    end
    if (set_ex) begin m_excpv = 1; m_excpid = ex_id; end
  endtask

  // One clock: check combinational outputs, clock, update model, check registered outputs.
  task automatic step();
    if (pre_ok) begin
      chk("alloc_ready", AllocReady, ((DEPTH - mq.size()) >= 4) ? 1 : 0);
      for (int k = 0; k < 4; k++)
        chk("alloc_rob_id", AllocRobId[k*ID_W +: ID_W], (m_tail + k) % DEPTH);
    end
    @(posedge Clk);
    #1;
    model_update();
    pre_ok = 1;
    chk("retire_able", RetireAble, e_rable);
    chk("free_able", FreeAble, e_fable);
    chk("retire_cnt", RetireCnt, e_cnt);
    for (int k = 0; k < e_cnt; k++) begin
      chk("retire_ar", RetireAR[k*ARCH_W +: ARCH_W], e_ar[k]);
      chk("retire_pr", RetirePR[k*PREG_W +: PREG_W], e_pr[k]);
      chk("free_pr", FreePR[k*PREG_W +: PREG_W], e_fpr[k]);
    end
`ifdef ROB_RETIRE_EXCP_EN
    chk("excp_valid", ExcpValid, m_excpv);
    if (m_excpv) chk("excp_rob_id", ExcpRobId, m_excpid);
`endif
  endtask

  task automatic do_alloc(input int n, input int phy_base);
    AllocValid = 4'((1 << n) - 1);
    AllocDestAble = 4'hF;
    for (int k = 0; k < 4; k++) begin
      AllocArch[k*ARCH_W +: ARCH_W] = ARCH_W'(k + 1);
      AllocPhy[k*PREG_W +: PREG_W]  = PREG_W'(phy_base + k);
      AllocOldPhy[k*PREG_W +: PREG_W] = PREG_W'(k + 1);
    end
    step();
    AllocValid = '0;
  endtask

  task automatic do_cmpl(input int id0, input int cnt);
    for (int k = 0; k < 4; k++) begin
      CmplAble[k] = (k < cnt);
      CmplRobId[k*ID_W +: ID_W] = ID_W'((id0 + k) % DEPTH);
    end
    step();
    CmplAble = '0;
  endtask

  typedef struct {
    logic [3:0] av; logic [3:0] ca; logic [19:0] cid; logic stop; logic flash;
    logic e_ready; int e_id0; int e_cnt; logic [3:0] e_rable;
  } vec_t;
  vec_t tbl[18];
  int wrap_ids[4];

  initial begin
    Rest = 1; Stop = 0; Flash = 0; AllocValid = '0; AllocDestAble = '0; AllocArch = '0;
    AllocPhy = '0; AllocOldPhy = '0; CmplAble = '0; CmplRobId = '0;
`ifdef ROB_RETIRE_EXCP_EN
    CmplExcp = '0;
`endif
    step();
    step();
    Rest = 0;

    //            av    ca    cid                             stp fl rdy id0 cnt rable
    tbl[0]  = '{4'hF, 4'h0, 20'h0,                            0, 0, 1, 0,  0, 4'h0};
    tbl[1]  = '{4'h0, 4'hF, {5'd3, 5'd2, 5'd1, 5'd0},         0, 0, 1, 4,  0, 4'h0};
    tbl[2]  = '{4'h0, 4'h0, 20'h0,                            0, 0, 1, 4,  4, 4'hF};
    tbl[3]  = '{4'hF, 4'h0, 20'h0,                            0, 0, 1, 4,  0, 4'h0};
    tbl[4]  = '{4'h0, 4'hE, {5'd7, 5'd6, 5'd5, 5'd0},         0, 0, 1, 8,  0, 4'h0};
    tbl[5]  = '{4'h0, 4'h0, 20'h0,                            0, 0, 1, 8,  0, 4'h0};
    tbl[6]  = '{4'h0, 4'h1, {5'd0, 5'd0, 5'd0, 5'd4},         0, 0, 1, 8,  0, 4'h0};
    tbl[7]  = '{4'h0, 4'h0, 20'h0,                            0, 0, 1, 8,  4, 4'hF};
    tbl[8]  = '{4'hF, 4'h0, 20'h0,                            0, 0, 1, 8,  0, 4'h0};
    tbl[9]  = '{4'hF, 4'h3, {5'd0, 5'd0, 5'd9, 5'd8},         1, 0, 1, 12, 0, 4'h0};
    tbl[10] = '{4'h0, 4'hC, {5'd11, 5'd10, 5'd0, 5'd0},       1, 0, 1, 12, 0, 4'h0};
    tbl[11] = '{4'h0, 4'h0, 20'h0,                            1, 0, 1, 12, 0, 4'h0};
    tbl[12] = '{4'h0, 4'h0, 20'h0,                            0, 0, 1, 12, 4, 4'hF};
    tbl[13] = '{4'hF, 4'h0, 20'h0,                            0, 0, 1, 12, 0, 4'h0};
    tbl[14] = '{4'hF, 4'h0, 20'h0,                            0, 0, 1, 16, 0, 4'h0};
    tbl[15] = '{4'h3, 4'h0, 20'h0,                            0, 0, 1, 20, 0, 4'h0};
    tbl[16] = '{4'hF, 4'hF, {5'd15, 5'd14, 5'd13, 5'd12},     0, 1, 1, 22, 0, 4'h0};
    tbl[17] = '{4'h0, 4'h0, 20'h0,                            0, 0, 1, 0,  0, 4'h0};

    AllocDestAble = 4'hF;
    AllocArch   = {5'd4, 5'd3, 5'd2, 5'd1};
    AllocPhy    = {7'd43, 7'd42, 7'd41, 7'd40};
    AllocOldPhy = {7'd4, 7'd3, 7'd2, 7'd1};
    for (int i = 0; i < 18; i++) begin
      AllocValid = tbl[i].av; CmplAble = tbl[i].ca; CmplRobId = tbl[i].cid;
      Stop = tbl[i].stop; Flash = tbl[i].flash;
      chk("tbl_ready", AllocReady, tbl[i].e_ready);
      chk("tbl_id0", AllocRobId[ID_W-1:0], tbl[i].e_id0);
      step();
      chk("tbl_cnt", RetireCnt, tbl[i].e_cnt);
      chk("tbl_rable", RetireAble, tbl[i].e_rable);
    end
    AllocValid = '0; CmplAble = '0; Stop = 0; Flash = 0;

    // Fill: Count 29 drops AllocReady, further requests are refused.
    for (int i = 0; i < 7; i++) do_alloc(4, 10 + 4 * i);
    do_alloc(1, 60);
    chk("full_ready", AllocReady, 0);
    chk("full_id0", AllocRobId[ID_W-1:0], 29);
    do_alloc(4, 70);
    chk("full_tail_hold", AllocRobId[ID_W-1:0], 29);
    for (int i = 0; i < 29; i += 4) do_cmpl(i, (29 - i) < 4 ? (29 - i) : 4);
    for (int i = 0; i < 4; i++) step();
    do_alloc(1, 80);
    do_cmpl(29, 1);
    step();
    step();

    // Wrap: ids 30,31,0,1 retire together in program order.
    wrap_ids = '{30, 31, 0, 1};
    for (int k = 0; k < 4; k++) chk("wrap_id", AllocRobId[k*ID_W +: ID_W], wrap_ids[k]);
    do_alloc(4, 100);
    do_cmpl(30, 4);
    step();
    chk("wrap_cnt", RetireCnt, 4);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_pr", RetirePR[k*PREG_W +: PREG_W], 100 + k);
      chk("wrap_ar", RetireAR[k*ARCH_W +: ARCH_W], k + 1);
    end

`ifdef ROB_RETIRE_EXCP_EN
    Flash = 1; step(); Flash = 0;
    do_alloc(4, 20);
    CmplExcp = 4'b0010;
    do_cmpl(0, 2);
    CmplExcp = '0;
    step();
    chk("excp_first_cnt", RetireCnt, 1);
    step();
    chk("excp_valid_set", ExcpValid, 1);
    chk("excp_id_set", ExcpRobId, 1);
    chk("excp_cnt_hold", RetireCnt, 0);
    do_cmpl(2, 2);
    step();
    chk("excp_blocked", RetireCnt, 0);
    Flash = 1; step(); Flash = 0;
    chk("excp_cleared", ExcpValid, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      int n, id;
      n = $urandom_range(0, 4);
      AllocValid = 4'((1 << n) - 1);
      AllocDestAble = 4'($urandom);
      AllocArch = 20'($urandom);
      AllocPhy = 28'($urandom);
      AllocOldPhy = 28'($urandom);
      for (int k = 0; k < 4; k++) begin
        CmplAble[k] = ($urandom_range(0, 2) != 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) id = mq[$urandom_range(0, mq.size() - 1)].id;
        else id = $urandom_range(0, DEPTH - 1);
        CmplRobId[k*ID_W +: ID_W] = ID_W'(id);
      end
`ifdef ROB_RETIRE_EXCP_EN
      for (int k = 0; k < 4; k++) CmplExcp[k] = ($urandom_range(0, 15) == 0);
`endif
      Stop  = ($urandom_range(0, 7) == 0);
`ifdef ROB_RETIRE_EXCP_EN
      Flash = ($urandom_range(0, 99) == 0) || (m_excpv && $urandom_range(0, 3) == 0);
`else
      Flash = ($urandom_range(0, 99) == 0);
`endif
      Rest  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
